// File: rtl/alu_nibble_seq_if.sv
// Command/response and ALU-side signal bundle for alu_nibble_seq.
// slave  : the controller
// master : command source, response consumer and the alu4 datapath
interface alu_nibble_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_c;
    logic           rsp_n;
    logic           rsp_z;
    logic           rsp_v;

    logic [2:0]     alu_op;
    logic [3:0]     alu_a;
    logic [3:0]     alu_b;
    logic           alu_ci;
    logic [3:0]     alu_result;
    logic           alu_c;
    logic           alu_v;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  alu_result, alu_c, alu_v,
        output cmd_ready, rsp_valid, rsp_result, rsp_c, rsp_n, rsp_z, rsp_v,
        output alu_op, alu_a, alu_b, alu_ci
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output alu_result, alu_c, alu_v,
        input  cmd_ready, rsp_valid, rsp_result, rsp_c, rsp_n, rsp_z, rsp_v,
        input  alu_op, alu_a, alu_b, alu_ci
    );
endinterface

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs W-bit commands through a shared 4-bit ALU one nibble
// per cycle (LSB first), chaining carries and building W-bit C/N/Z/V flags.
// Optional feature macro: SEQ_SATURATE_EN (clamp ADD/SUB results on overflow).
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_nibble_seq_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic [IW-1:0]   r_idx;
    logic            r_c;
    logic            r_v;
    logic            r_zacc;

    logic            w_arith;
    logic            w_sub;
    logic            w_last;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [W-1:0]    w_out;
    logic            w_z;

    logic            w_cmd_ready;
    logic            w_rsp_valid;
    logic [2:0]      w_alu_op;
    logic [3:0]      w_alu_a;
    logic [3:0]      w_alu_b;
    logic            w_alu_ci;

    // ADD (110) and SUB (111) both go through the ALU's add mode; SUB inverts B
    assign w_arith = (r_op[2:1] == 2'b11);
    assign w_sub   = (r_op == 3'b111);
    assign w_last  = (r_idx == IW'(NIBBLES - 1));
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

`ifdef SEQ_SATURATE_EN
    // overflowed ADD/SUB clamps toward the sign the wrapped result carries
    assign w_out = (w_arith && r_v) ?
                   (r_res[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
                   r_res;
    // a clamped value is never zero
    assign w_z   = r_zacc && !(w_arith && r_v);
`else
    assign w_out = r_res;
    assign w_z   = r_zacc;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next state, handshake and ALU drive; ALU outputs are zero outside RUN
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_alu_op    = 3'b000;
        w_alu_a     = 4'h0;
        w_alu_b     = 4'h0;
        w_alu_ci    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next = S_RUN;
            end
            S_RUN: begin
                w_alu_a = w_a_nib;
                if (w_arith) begin
                    w_alu_op = 3'b110;
                    w_alu_b  = w_sub ? ~w_b_nib : w_b_nib;
                    w_alu_ci = (r_idx == '0) ? w_sub : r_c;
                end else begin
                    w_alu_op = r_op;
                    w_alu_b  = w_b_nib;
                end
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // command latch and per-nibble accumulation of result and flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_idx  <= '0;
            r_c    <= 1'b0;
            r_v    <= 1'b0;
            r_zacc <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op   <= bus.cmd_op;
                        r_a    <= bus.cmd_a;
                        r_b    <= bus.cmd_b;
                        r_res  <= '0;
                        r_idx  <= '0;
                        r_c    <= 1'b0;
                        r_v    <= 1'b0;
                        r_zacc <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_res[{r_idx, 2'b00} +: 4] <= bus.alu_result;
                    r_c    <= w_arith & bus.alu_c;
                    r_zacc <= r_zacc & (bus.alu_result == 4'h0);
                    if (w_last) r_v   <= w_arith & bus.alu_v;
                    else        r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // response fields are only presented while the response is pending
    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = w_rsp_valid ? w_out : '0;
    assign bus.rsp_c      = w_rsp_valid & r_c;
    assign bus.rsp_n      = w_rsp_valid & w_out[W-1];
    assign bus.rsp_z      = w_rsp_valid & w_z;
    assign bus.rsp_v      = w_rsp_valid & r_v;
    assign bus.alu_op     = w_alu_op;
    assign bus.alu_a      = w_alu_a;
    assign bus.alu_b      = w_alu_b;
    assign bus.alu_ci     = w_alu_ci;
endmodule
